// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: architectural register file shape,
// forwarding-select encodings and result-latency codes.
package mips_pkg;

  localparam int NREG = 32;
  localparam int RA_W = 5;

  localparam int FWD_RF = 0;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // A zero latency tag means a plain ALU result.
  function automatic int eff_lat(input int lat);
    return (lat == 0) ? LAT_ALU : lat;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source register against every in-flight stage entry;
// reports any match, whether a match is still too late to forward, and the
// forward select of the youngest producer.
module hazard_match #(
  parameter int RA_W   = 5,
  parameter int NSTAGE = 3,
  parameter int LAT_W  = 2,
  parameter int SEL_W  = 2
) (
  input  logic [RA_W-1:0]              src,
  input  logic                         uses,
  input  logic [NSTAGE-1:0]            valid,
  input  logic [NSTAGE-1:0][RA_W-1:0]  rd,
  input  logic [NSTAGE-1:0][LAT_W-1:0] lat,
  output logic                         hit,
  output logic                         late,
  output logic [SEL_W-1:0]             sel
);
  import mips_pkg::*;

  // Stage k lives at index k-1; the last stage retires through the regfile
  // write-through and is never a hazard. Walking oldest to youngest lets the
  // youngest producer overwrite sel.
  always_comb begin
    hit  = 1'b0;
    late = 1'b0;
    sel  = '0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (uses && (src != '0) && valid[k-1] && (rd[k-1] == src)) begin
        hit = 1'b1;
        sel = SEL_W'(k + 1);
        if ((k + 1) <= eff_lat(int'(lat[k-1]))) late = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight register writes, raises the
// decode stall, registers the EX forwarding selects and counts stall cycles.
module hazard_scoreboard #(
  parameter int NREG        = mips_pkg::NREG,
  parameter int RA_W        = mips_pkg::RA_W,
  parameter int NSTAGE      = 3,
  parameter int LAT_W       = 2,
  parameter int FWD_EN      = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = $clog2(NSTAGE + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] ex_fwd_a,
  output logic [SEL_W-1:0] ex_fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  import mips_pkg::*;

  logic [NSTAGE-1:0]            valid_q;
  logic [NSTAGE-1:0][RA_W-1:0]  rd_q;
  logic [NSTAGE-1:0][LAT_W-1:0] lat_q;

  logic             hit_a, hit_b, late_a, late_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             insert;
  logic             writes_reg;

  hazard_match #(.RA_W(RA_W), .NSTAGE(NSTAGE), .LAT_W(LAT_W), .SEL_W(SEL_W)) u_match_rs (
    .src(id_rs), .uses(id_uses_rs), .valid(valid_q), .rd(rd_q), .lat(lat_q),
    .hit(hit_a), .late(late_a), .sel(sel_a)
  );

  hazard_match #(.RA_W(RA_W), .NSTAGE(NSTAGE), .LAT_W(LAT_W), .SEL_W(SEL_W)) u_match_rt (
    .src(id_rt), .uses(id_uses_rt), .valid(valid_q), .rd(rd_q), .lat(lat_q),
    .hit(hit_b), .late(late_b), .sel(sel_b)
  );

  // Without forwarding every match must wait for the regfile write-through.
  assign stall = id_valid && !flush &&
                 ((FWD_EN != 0) ? (late_a || late_b) : (hit_a || hit_b));

  assign insert     = id_valid && !stall && !flush;
  assign writes_reg = id_wr_en && (id_rd != '0) && (int'(id_rd) < NREG);
  assign busy       = |valid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= '0;
      rd_q      <= '0;
      lat_q     <= '0;
      ex_fwd_a  <= SEL_W'(FWD_RF);
      ex_fwd_b  <= SEL_W'(FWD_RF);
      stall_cnt <= '0;
    end else begin
      valid_q[0] <= insert && writes_reg;
      rd_q[0]    <= id_rd;
      lat_q[0]   <= id_lat;
      // Entries in the youngest FLUSH_DEPTH stages are squashed as they advance.
      for (int k = 1; k < NSTAGE; k++) begin
        valid_q[k] <= valid_q[k-1] && !(flush && (k <= FLUSH_DEPTH));
        rd_q[k]    <= rd_q[k-1];
        lat_q[k]   <= lat_q[k-1];
      end

      if (insert && (FWD_EN != 0)) begin
        ex_fwd_a <= sel_a;
        ex_fwd_b <= sel_b;
      end else begin
        ex_fwd_a <= SEL_W'(FWD_RF);
        ex_fwd_b <= SEL_W'(FWD_RF);
      end

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one forwarding and one stall-until-writeback
// instance share stimulus and are checked every cycle against a queue model.
module tb_hazard_scoreboard;
  localparam int NSTAGE = 3;
  localparam int FD     = 1;
  localparam int CMAX   = 65535;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_wr_en = 1'b0;
  logic [1:0] id_lat = '0;
  logic       flush = 1'b0;

  // index 0: FWD_EN=0, index 1: FWD_EN=1
  logic        stall_w [2];
  logic [1:0]  fa_w    [2];
  logic [1:0]  fb_w    [2];
  logic        busy_w  [2];
  logic [15:0] cnt_w   [2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGE(NSTAGE), .FWD_EN(0), .FLUSH_DEPTH(FD)) dut0 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_lat(id_lat), .flush(flush), .stall(stall_w[0]), .ex_fwd_a(fa_w[0]),
    .ex_fwd_b(fb_w[0]), .busy(busy_w[0]), .stall_cnt(cnt_w[0])
  );

  hazard_scoreboard #(.NSTAGE(NSTAGE), .FWD_EN(1), .FLUSH_DEPTH(FD)) dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_lat(id_lat), .flush(flush), .stall(stall_w[1]), .ex_fwd_a(fa_w[1]),
    .ex_fwd_b(fb_w[1]), .busy(busy_w[1]), .stall_cnt(cnt_w[1])
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each in-flight producer is remembered with its age: age a means it now
  // sits in stage a. Mode m says whether forwarding is enabled.
  typedef struct {
    int m;
    int rd;
    int lat;
    int age;
  } prod_t;

  prod_t q[$];
  int exp_fa [2] = '{0, 0};
  int exp_fb [2] = '{0, 0};
  int exp_cnt[2] = '{0, 0};

  function automatic void scan(input int m, input int src, input bit use_it,
                               output bit hit, output bit late, output int sel);
    int ready_at;
    hit = 0; late = 0; sel = 0;
    if (!use_it || src == 0) return;
    foreach (q[i]) begin
      if (q[i].m == m && q[i].age < NSTAGE && q[i].rd == src) begin
        hit = 1;
        ready_at = (q[i].lat == 0) ? 1 : q[i].lat;
        // Consumer reaches EX when producer is one stage further on.
        if (q[i].age + 1 <= ready_at) late = 1;
        if (sel == 0 || q[i].age + 1 < sel) sel = q[i].age + 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit ha, la, hb, lb, st, ins, any;
      int sa, sb;
      scan(m, int'(id_rs), id_uses_rs, ha, la, sa);
      scan(m, int'(id_rt), id_uses_rt, hb, lb, sb);
      st = id_valid && !flush && ((m == 1) ? (la || lb) : (ha || hb));
      any = 0;
      foreach (q[i]) if (q[i].m == m) any = 1;

      chk($sformatf("model_stall_m%0d", m), int'(stall_w[m]), int'(st));
      chk($sformatf("model_busy_m%0d", m), int'(busy_w[m]), int'(any));
      chk($sformatf("model_fwd_a_m%0d", m), int'(fa_w[m]), exp_fa[m]);
      chk($sformatf("model_fwd_b_m%0d", m), int'(fb_w[m]), exp_fb[m]);
      chk($sformatf("model_cnt_m%0d", m), int'(cnt_w[m]), exp_cnt[m]);

      if (!reset_n) begin
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].m == m) q.delete(i);
        exp_fa[m] = 0; exp_fb[m] = 0; exp_cnt[m] = 0;
      end else begin
        ins = id_valid && !st && !flush;
        exp_fa[m] = (ins && m == 1) ? sa : 0;
        exp_fb[m] = (ins && m == 1) ? sb : 0;
        if (st && exp_cnt[m] != CMAX) exp_cnt[m]++;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].m == m) begin
            if (flush && q[i].age <= FD) q.delete(i);
            else if (q[i].age + 1 > NSTAGE) q.delete(i);
            else q[i].age++;
          end
        end
        if (ins && id_wr_en && id_rd != 0)
          q.push_back('{m: m, rd: int'(id_rd), lat: int'(id_lat), age: 1});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rn, input bit v, input bit fl,
                       input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input int rd, input int lat);
    @(posedge clk); #1;
    reset_n = rn; id_valid = v; flush = fl;
    id_rs = 5'(rs); id_uses_rs = urs; id_rt = 5'(rt); id_uses_rt = urt;
    id_wr_en = wr; id_rd = 5'(rd); id_lat = 2'(lat);
  endtask

  task automatic nop();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_cnt", int'(cnt_w[1]), 0);
    chk("reset_busy", int'(busy_w[1]), 0);
    chk("reset_fwd_a", int'(fa_w[1]), 0);

    // back-to-back ALU
    drive(1, 1, 0, 0, 0, 0, 0, 1, 3, 1);
    drive(1, 1, 0, 3, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("b2b_stall", int'(stall_w[1]), 0);
    nop();
    @(negedge clk); chk("b2b_fwd_a", int'(fa_w[1]), 2);
    nop(); nop(); nop();

    // load-use
    drive(1, 1, 0, 0, 0, 0, 0, 1, 5, 2);
    drive(1, 1, 0, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk); chk("lu_stall1", int'(stall_w[1]), 1);
    drive(1, 1, 0, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk); chk("lu_stall2", int'(stall_w[1]), 0);
    nop();
    @(negedge clk);
    chk("lu_fwd_b", int'(fb_w[1]), 3);
    chk("lu_cnt", int'(cnt_w[1]), 1);
    nop(); nop(); nop();

    // zero register
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_stall", int'(stall_w[1]), 0);
    chk("zero_busy", int'(busy_w[1]), 0);
    nop();
    @(negedge clk); chk("zero_fwd_a", int'(fa_w[1]), 0);
    nop(); nop();

    // double producer, youngest wins
    drive(1, 1, 0, 0, 0, 0, 0, 1, 7, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 7, 1);
    drive(1, 1, 0, 7, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("dbl_stall", int'(stall_w[1]), 0);
    nop();
    @(negedge clk); chk("dbl_fwd_a", int'(fa_w[1]), 2);
    nop(); nop(); nop();

    // flush during load-use stall
    drive(1, 1, 0, 0, 0, 0, 0, 1, 5, 2);
    drive(1, 1, 1, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk); chk("fl_stall", int'(stall_w[1]), 0);
    nop();
    @(negedge clk);
    chk("fl_busy", int'(busy_w[1]), 0);
    chk("fl_fwd_b", int'(fb_w[1]), 0);

    // stall-until-writeback instance
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 4, 1);
    drive(1, 1, 0, 4, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("nf_stall1", int'(stall_w[0]), 1);
    drive(1, 1, 0, 4, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("nf_stall2", int'(stall_w[0]), 1);
    drive(1, 1, 0, 4, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("nf_stall3", int'(stall_w[0]), 0);
    nop();
    @(negedge clk);
    chk("nf_fwd_a", int'(fa_w[0]), 0);
    chk("nf_cnt", int'(cnt_w[0]), 2);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 6, 2);
    nop();
    @(negedge clk);
    chk("nf_rst_cnt", int'(cnt_w[0]), 0);
    chk("nf_rst_busy", int'(busy_w[0]), 0);

    // randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 9) == 0),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3));
    end
    nop();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
